// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog timeout escalation controller.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WARN  = 2'b01,
    ST_RESET = 2'b10
  } wdt_state_e;

  localparam int WDT_GRACE_CYCLES_DEF     = 8;
  localparam int WDT_RST_PULSE_CYCLES_DEF = 4;
  localparam int WDT_RST_CNT_W_DEF        = 4;

  function automatic int wdt_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wdt_cycle_timer.sv
// Loadable down-counter shared by the grace window and the reset pulse.
module wdt_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdt_escalation.sv
// Escalates a watchdog timeout to a warning interrupt, then to a fixed-width
// system reset pulse if software does not acknowledge within the grace window.
module wdt_escalation
  import wdt_pkg::*;
#(
  parameter int GRACE_CYCLES     = WDT_GRACE_CYCLES_DEF,
  parameter int RST_PULSE_CYCLES = WDT_RST_PULSE_CYCLES_DEF,
  parameter int RST_CNT_W        = WDT_RST_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 timeout,
  input  logic                 irq_ack,
  input  logic                 clear_count,
  output logic                 irq,
  output logic                 wd_restart,
  output logic                 sys_reset,
  output logic [RST_CNT_W-1:0] reset_count
);

  localparam int TMR_W = $clog2(wdt_max(GRACE_CYCLES, RST_PULSE_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] GRACE_LOAD = TMR_W'(GRACE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [RST_CNT_W-1:0] CNT_MAX = '1;

  wdt_state_e           state_q;
  logic                 timeout_q;
  logic                 irq_q;
  logic                 wd_restart_q;
  logic                 sys_reset_q;
  logic [RST_CNT_W-1:0] reset_count_q;
  logic [RST_CNT_W-1:0] reset_count_d;
  logic                 rise_s;
  logic                 escalate_s;
  logic                 tmr_load_s;
  logic                 tmr_zero_s;
  logic [TMR_W-1:0]     tmr_load_val_s;

  wdt_cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_load_val_s),
    .zero_o     (tmr_zero_s)
  );

  // Edge detect, timer load decode and saturating counter next-state.
  always_comb begin
    rise_s         = timeout & ~timeout_q;
    escalate_s     = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = GRACE_LOAD;
    case (state_q)
      ST_IDLE: begin
        tmr_load_s     = rise_s;
        tmr_load_val_s = GRACE_LOAD;
      end
      ST_WARN: begin
        escalate_s     = tmr_zero_s & ~irq_ack;
        tmr_load_s     = escalate_s;
        tmr_load_val_s = PULSE_LOAD;
      end
      default: begin
        tmr_load_s     = 1'b0;
        tmr_load_val_s = GRACE_LOAD;
      end
    endcase
    // Clear beats a coinciding increment.
    if (clear_count) begin
      reset_count_d = '0;
    end else if (escalate_s && (reset_count_q != CNT_MAX)) begin
      reset_count_d = reset_count_q + RST_CNT_W'(1);
    end else begin
      reset_count_d = reset_count_q;
    end
  end

  // Timeout history and escalation event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q     <= 1'b0;
      reset_count_q <= '0;
    end else begin
      timeout_q     <= timeout;
      reset_count_q <= reset_count_d;
    end
  end

  // Escalation FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      wd_restart_q <= 1'b0;
      sys_reset_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_restart_q <= 1'b0;
          sys_reset_q  <= 1'b0;
          if (rise_s) begin
            state_q <= ST_WARN;
            irq_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        ST_WARN: begin
          if (irq_ack) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            wd_restart_q <= 1'b1;
            sys_reset_q  <= 1'b0;
          end else if (tmr_zero_s) begin
            state_q      <= ST_RESET;
            irq_q        <= 1'b0;
            wd_restart_q <= 1'b1;
            sys_reset_q  <= 1'b1;
          end else begin
            state_q      <= ST_WARN;
            irq_q        <= 1'b1;
            wd_restart_q <= 1'b0;
            sys_reset_q  <= 1'b0;
          end
        end
        ST_RESET: begin
          irq_q <= 1'b0;
          if (tmr_zero_s) begin
            state_q      <= ST_IDLE;
            wd_restart_q <= 1'b0;
            sys_reset_q  <= 1'b0;
          end else begin
            state_q      <= ST_RESET;
            wd_restart_q <= 1'b1;
            sys_reset_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          irq_q        <= 1'b0;
          wd_restart_q <= 1'b0;
          sys_reset_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq         = irq_q;
  assign wd_restart  = wd_restart_q;
  assign sys_reset   = sys_reset_q;
  assign reset_count = reset_count_q;

endmodule

// File: tb/tb_wdt_escalation.sv
// Bench for wdt_escalation: per-cycle reference model, directed scenarios and
// randomized stimulus, with a small watchdog model to close the restart loop.
module tb_wdt_escalation;

  localparam int G = 8;
  localparam int P = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq_ack = 1'b0;
  logic clear_count = 1'b0;
  logic to_drv = 1'b0;
  logic use_wd = 1'b0;
  logic timeout;
  logic irq, wd_restart, sys_reset;
  logic [CW-1:0] reset_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, expressed in terms of the visible outputs.
  int m_irq, m_wdr, m_sys, m_cnt, m_prev_to, m_warn_n, m_rst_left;
  int wd_cnt;
  int hi_irq, hi_wdr, hi_sys, sys_rises, irq_run, prev_sys;

  always #5 clk = ~clk;

  assign timeout = use_wd ? (wd_cnt == 15) : to_drv;

  wdt_escalation #(
    .GRACE_CYCLES     (G),
    .RST_PULSE_CYCLES (P),
    .RST_CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .timeout     (timeout),
    .irq_ack     (irq_ack),
    .clear_count (clear_count),
    .irq         (irq),
    .wd_restart  (wd_restart),
    .sys_reset   (sys_reset),
    .reset_count (reset_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural 4-bit watchdog: counts up to 15 and holds, cleared by restart.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= 0;
    else if (wd_restart) wd_cnt <= 0;
    else if (wd_cnt != 15) wd_cnt <= wd_cnt + 1;
  end

  // Reference model: next outputs from the current outputs and sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_irq <= 0; m_wdr <= 0; m_sys <= 0; m_cnt <= 0;
      m_prev_to <= 0; m_warn_n <= 0; m_rst_left <= 0;
    end else begin
      m_prev_to <= int'(timeout);
      if (clear_count) m_cnt <= 0;
      else if (m_irq == 1 && !irq_ack && m_warn_n == G) m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (m_sys == 1) begin
        if (m_rst_left == 1) begin m_sys <= 0; m_wdr <= 0; end
        m_rst_left <= m_rst_left - 1;
      end else if (m_irq == 1) begin
        if (irq_ack) begin
          m_irq <= 0; m_wdr <= 1;
        end else if (m_warn_n == G) begin
          m_irq <= 0; m_sys <= 1; m_wdr <= 1; m_rst_left <= P;
        end else begin
          m_warn_n <= m_warn_n + 1;
        end
      end else begin
        m_wdr <= 0;
        if (timeout && m_prev_to == 0) begin m_irq <= 1; m_warn_n <= 1; end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("irq", int'(irq), m_irq);
    chk("wd_restart", int'(wd_restart), m_wdr);
    chk("sys_reset", int'(sys_reset), m_sys);
    chk("reset_count", int'(reset_count), m_cnt);
  end

  // One cycle: sample outputs mid-cycle, then step to just after the next edge.
  task automatic cyc();
    @(negedge clk);
    hi_irq += int'(irq);
    hi_wdr += int'(wd_restart);
    hi_sys += int'(sys_reset);
    if (sys_reset && prev_sys == 0) sys_rises++;
    prev_sys = int'(sys_reset);
    irq_run = irq ? irq_run + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hist();
    hi_irq = 0; hi_wdr = 0; hi_sys = 0;
  endtask

  task automatic idle(input int n);
    irq_ack = 1'b0; to_drv = 1'b0; use_wd = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Raise timeout, optionally ack in WARN cycle ack_at (1-based), run nc cycles.
  task automatic run_scn(input int ack_at, input int nc, input bit rise_in_rst);
    clr_hist();
    to_drv = 1'b1;
    for (int i = 0; i < nc; i++) begin
      irq_ack = (i == ack_at);
      if (i == 2) to_drv = 1'b0;
      if (rise_in_rst && i == 11) to_drv = 1'b1;
      cyc();
    end
    irq_ack = 1'b0; to_drv = 1'b0;
  endtask

  initial begin
    int c0;
    bit found;
    hi_irq = 0; hi_wdr = 0; hi_sys = 0; sys_rises = 0; irq_run = 0; prev_sys = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", int'(irq), 0);
    chk("rst_sys", int'(sys_reset), 0);
    chk("rst_cnt", int'(reset_count), 0);
    rst_n = 1'b1;
    idle(3);

    // Ack in the 3rd WARN cycle.
    c0 = int'(reset_count);
    run_scn(3, 20, 1'b0);
    chk("ack3_irq_cycles", hi_irq, 3);
    chk("ack3_wdr_cycles", hi_wdr, 1);
    chk("ack3_sys_cycles", hi_sys, 0);
    chk("ack3_cnt", int'(reset_count), c0);

    // No ack, plus a timeout rise during RESET that must be ignored.
    idle(3);
    run_scn(-1, 24, 1'b1);
    chk("noack_irq_cycles", hi_irq, G);
    chk("noack_sys_cycles", hi_sys, P);
    chk("noack_wdr_cycles", hi_wdr, P);
    chk("noack_cnt", int'(reset_count), 1);

    // Ack in the final grace cycle wins.
    idle(3);
    run_scn(8, 20, 1'b0);
    chk("ack8_irq_cycles", hi_irq, G);
    chk("ack8_sys_cycles", hi_sys, 0);
    chk("ack8_wdr_cycles", hi_wdr, 1);
    chk("ack8_cnt", int'(reset_count), 1);

    // Ack while idle does nothing.
    idle(3);
    clr_hist();
    irq_ack = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    irq_ack = 1'b0;
    chk("idle_ack_outputs", hi_irq + hi_wdr + hi_sys, 0);

    // Saturation over 17+ watchdog-driven escalations.
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("clear_cnt", int'(reset_count), 0);
    sys_rises = 0;
    use_wd = 1'b1;
    for (int i = 0; i < 17 * (P + 16 + G) + 60; i++) cyc();
    chk("sat_escalations_ge17", int'(sys_rises >= 17), 1);
    chk("sat_cnt", int'(reset_count), CMAX);

    // Clear coinciding with an increment.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (irq_run == G - 1) found = 1'b1;
    end
    chk("find_warn7", int'(found), 1);
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("coincide_sys", int'(sys_reset), 1);
    chk("coincide_cnt", int'(reset_count), 0);
    idle(40);

    // Reset asserted in the 2nd sys_reset cycle, released with timeout high.
    clr_hist();
    to_drv = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("pre_rst_sys", int'(sys_reset), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", int'(irq), 0);
    chk("mid_rst_wdr", int'(wd_restart), 0);
    chk("mid_rst_sys", int'(sys_reset), 0);
    chk("mid_rst_cnt", int'(reset_count), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("release_irq_low", int'(irq), 0);
    cyc();
    chk("release_irq_rise", int'(irq), 1);
    idle(20);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n       = ($urandom_range(0, 299) != 0);
      use_wd      = ($urandom_range(0, 3) == 0) ? ~use_wd : use_wd;
      to_drv      = ($urandom_range(0, 4) == 0) ? ~to_drv : to_drv;
      irq_ack     = ($urandom_range(0, 9) == 0);
      clear_count = ($urandom_range(0, 39) == 0);
    end
    rst_n = 1'b1; irq_ack = 1'b0; clear_count = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wdt_escalation.md
# wdt_escalation

Timeout escalation controller sitting directly downstream of the 4-bit watchdog counter. It consumes the watchdog's level `timeout` and first raises a warning interrupt. If software does not acknowledge within a grace window, it issues a fixed-width system reset pulse and counts the event. It drives the watchdog's `restart` input, so the counter re-arms after every acknowledged or escalated timeout.

## Interface
- `GRACE_CYCLES`, 8, cycles in WARN during which `irq_ack` is accepted (≥1)
- `RST_PULSE_CYCLES`, 4, width of `sys_reset` pulse in cycles (≥1)
- `RST_CNT_W`, 4, width of saturating reset-event counter (≥1)

Ports:
- `clk` in 1: single clock, rising edge; same clock as the watchdog
- `rst_n` in 1: asynchronous, active-low reset
- `timeout` in 1: watchdog timeout level; high while watchdog count = 15
- `irq_ack` in 1: software acknowledge, sampled each cycle
- `clear_count` in 1: synchronous clear of `reset_count`
- `irq` out 1: warning interrupt, registered
- `wd_restart` out 1: to watchdog `restart`, registered
- `sys_reset` out 1: active-high system reset pulse, registered
- `reset_count` out `RST_CNT_W`: number of escalated resets, saturating

## Operation
- Rising-edge detect on `timeout` uses register `timeout_q`.
  - Rise = `timeout & ~timeout_q`.
  - `timeout_q` resets to 0, so `timeout` high at reset release counts as a rise.
- States: IDLE, WARN, RESET.
- IDLE:
  - All outputs low except `reset_count`.
  - Rise → WARN, `irq`←1, grace timer←`GRACE_CYCLES`-1.
  - `irq_ack` is ignored.
- WARN:
  - `irq` held high. The timer decrements each cycle.
  - `irq_ack`=1 → IDLE, `irq`←0, `wd_restart`←1 for exactly one cycle.
  - Timer = 0 and no ack → RESET, `irq`←0, `sys_reset`←1, `wd_restart`←1, timer←`RST_PULSE_CYCLES`-1, `reset_count` increments.
  - Ack in the final grace cycle wins over escalation.
  - `timeout` falling during WARN does not abort; only an ack aborts.
- RESET:
  - `sys_reset` and `wd_restart` are held high. The timer decrements.
  - Timer = 0 → IDLE; both outputs go low on that edge.
  - `irq_ack` and `timeout` rises are ignored.
- `reset_count`:
  - Increments once per WARN→RESET transition and saturates at 2^`RST_CNT_W`-1.
  - `clear_count` has priority: if clear and increment coincide, the result is 0.
  - Clearing is allowed in any state.
- Reset (`rst_n`=0): state IDLE; `irq`, `wd_restart`, `sys_reset`, `timeout_q`, timer and `reset_count` all 0. This applies immediately, mid-WARN or mid-RESET, and a truncated `sys_reset` pulse is acceptable.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Rise at cycle N → `irq` high from N+1.
- Ack sampled at cycle M in WARN → `irq` low and `wd_restart` high at M+1, `wd_restart` low at M+2.
- Unacknowledged:
  - `irq` is high for exactly `GRACE_CYCLES` cycles.
  - `sys_reset` rises the cycle after the last WARN cycle and stays high exactly `RST_PULSE_CYCLES` cycles.
- The watchdog clears on the edge that samples `wd_restart`=1, so `timeout` falls one cycle after `wd_restart` rises. `timeout_q` therefore sees a clean low before the next rise.
- Minimum spacing between escalations is `RST_PULSE_CYCLES` + 16 + `GRACE_CYCLES` cycles with the watchdog enabled.

## Structure
- Package `wdt_pkg`:
  - state encoding: IDLE=2'b00, WARN=2'b01, RESET=2'b10; 2'b11 recovers to IDLE
  - default parameter constants
- Sub-module `wdt_cycle_timer`:
  - loadable down-counter, width $clog2(max(`GRACE_CYCLES`,`RST_PULSE_CYCLES`))+1
  - `load`, `load_val`, `zero` flag
  - instantiated once and shared by WARN and RESET
- Top level holds the FSM, edge detector and saturating counter.

## Test plan
Parameters for all scenarios: `GRACE_CYCLES`=8, `RST_PULSE_CYCLES`=4, `RST_CNT_W`=4.
- `timeout` rises, `irq_ack` pulsed on the 3rd WARN cycle → `irq` high 3 cycles, one-cycle `wd_restart`, `sys_reset` never high, `reset_count`=0.
- No ack → `irq` high 8 cycles, then `sys_reset` and `wd_restart` high 4 cycles, `reset_count`=1, state IDLE afterwards.
- Ack in the 8th WARN cycle → no `sys_reset`; ack wins.
- 17 consecutive escalations → `reset_count` saturates at 15. `clear_count` on the cycle of an increment → 0.
- `rst_n` low during the 2nd cycle of `sys_reset` → all outputs 0 immediately. After release with `timeout` still high → `irq` rises one cycle later.
- `irq_ack` in IDLE and a `timeout` rise during RESET → no state change, no output glitch.
